// File: rtl/ar_rr_arbiter.sv
// ar_rr_arbiter
//   Merges N = 2**LOG_PORTS upstream AR channels into one AR channel using a
//   round-robin grant, and routes the merged R channel back to the port
//   encoded in the upper LOG_PORTS bits of the returned ID.
//
//   Optional feature: define AR_ARB_PERF_CNT_EN to add the performance
//   counter outputs perf_grant_cnt / perf_stall_cnt.
//
// Ports
//   clk, resetN                       clock, synchronous active-low reset
//   s_ar_valid/ready [N]              per-port AR handshake
//   s_ar_addr/len/id  (flattened)     per-port AR payload, port k at slice k
//   m_ar_valid/ready, m_ar_addr/len/id  merged AR (one-entry register)
//   m_r_valid/ready/last/data/id      merged R from downstream
//   s_r_valid/last [N], s_r_ready [N] per-port R handshake
//   s_r_data, s_r_id                  shared per-port R payload
//   err_underflow                     sticky: R-last returned to an idle port
//   perf_grant_cnt [N*32]             grants per port (AR_ARB_PERF_CNT_EN)
//   perf_stall_cnt [32]               cycles m_ar_valid & !m_ar_ready (AR_ARB_PERF_CNT_EN)
module ar_rr_arbiter #(
    parameter int ADDR_BITS            = 16,
    parameter int TID_WIDTH            = 8,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 8,
    parameter int LOG_PORTS            = 2,
    parameter int OUTSTAND_WIDTH       = 4,
    localparam int N      = 1 << LOG_PORTS,
    localparam int DATA_W = 8 << LOG_BLOCK_DATA_BYTES,
    localparam int LOW_ID = TID_WIDTH - LOG_PORTS
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [N-1:0]                 s_ar_valid,
    output logic [N-1:0]                 s_ar_ready,
    input  logic [N*ADDR_BITS-1:0]       s_ar_addr,
    input  logic [N*BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [N*TID_WIDTH-1:0]       s_ar_id,
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [ADDR_BITS-1:0]         m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
    output logic [TID_WIDTH-1:0]         m_ar_id,
    input  logic                         m_r_valid,
    output logic                         m_r_ready,
    input  logic                         m_r_last,
    input  logic [DATA_W-1:0]            m_r_data,
    input  logic [TID_WIDTH-1:0]         m_r_id,
    output logic [N-1:0]                 s_r_valid,
    output logic [N-1:0]                 s_r_last,
    input  logic [N-1:0]                 s_r_ready,
    output logic [DATA_W-1:0]            s_r_data,
    output logic [TID_WIDTH-1:0]         s_r_id,
    output logic                         err_underflow
`ifdef AR_ARB_PERF_CNT_EN
    ,
    output logic [N*32-1:0]              perf_grant_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    typedef logic [LOG_PORTS-1:0] port_t;

    logic                       ar_valid_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [TID_WIDTH-1:0]       id_q;
    port_t                      ptr_q;
    logic [OUTSTAND_WIDTH-1:0]  outstanding_q [N];
    logic                       err_q;

    logic [N-1:0]               eligible;
    logic                       grant_any;
    port_t                      grant_idx;
    port_t                      idx;
    logic                       load_ok;
    logic [ADDR_BITS-1:0]       sel_addr;
    logic [BURST_LEN_WIDTH-1:0] sel_len;
    logic [LOW_ID-1:0]          sel_id_low;
    logic                       unused_id_bits;

    port_t                      r_port;
    logic                       r_last_hs;
    logic [N-1:0]               r_dec;

    // Grant search and payload select
    always_comb begin
        eligible       = '0;
        grant_any      = 1'b0;
        grant_idx      = '0;
        idx            = '0;
        sel_addr       = '0;
        sel_len        = '0;
        sel_id_low     = '0;
        unused_id_bits = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            eligible[k] = s_ar_valid[k] && (outstanding_q[k] != '1);
        end
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr_q + port_t'(i);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (port_t'(k) == grant_idx) begin
                sel_addr   = s_ar_addr[k*ADDR_BITS +: ADDR_BITS];
                sel_len    = s_ar_len[k*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
                sel_id_low = s_ar_id[k*TID_WIDTH +: LOW_ID];
            end
            // Upper ID bits are replaced by the port number downstream
            unused_id_bits = unused_id_bits ^ (^s_ar_id[k*TID_WIDTH+LOW_ID +: LOG_PORTS]);
        end
        load_ok    = resetN && (!ar_valid_q || m_ar_ready);
        s_ar_ready = '0;
        s_ar_ready[grant_idx] = load_ok && grant_any;
    end

    // R routing is purely combinational, independent of reset
    always_comb begin
        r_port    = m_r_id[TID_WIDTH-1 -: LOG_PORTS];
        s_r_valid = '0;
        s_r_last  = '0;
        s_r_valid[r_port] = m_r_valid;
        s_r_last[r_port]  = m_r_last;
        m_r_ready = s_r_ready[r_port];
        s_r_data  = m_r_data;
        s_r_id    = {{LOG_PORTS{1'b0}}, m_r_id[LOW_ID-1:0]};
        r_last_hs = m_r_valid && m_r_ready && m_r_last;
        r_dec     = '0;
        r_dec[r_port] = r_last_hs;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            ar_valid_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                outstanding_q[k] <= '0;
            end
        end else begin
            if (|s_ar_ready) begin
                ar_valid_q <= 1'b1;
                addr_q     <= sel_addr;
                len_q      <= sel_len;
                id_q       <= {grant_idx, sel_id_low};
                ptr_q      <= grant_idx + port_t'(1);
            end else if (m_ar_ready) begin
                ar_valid_q <= 1'b0;
            end
            for (int unsigned k = 0; k < N; k++) begin
                if (s_ar_ready[k] && !r_dec[k]) begin
                    outstanding_q[k] <= outstanding_q[k] + 1'b1;
                end else if (r_dec[k] && !s_ar_ready[k]) begin
                    // Saturate at zero and flag instead of wrapping
                    if (outstanding_q[k] == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        outstanding_q[k] <= outstanding_q[k] - 1'b1;
                    end
                end
            end
        end
    end

`ifdef AR_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetN) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (s_ar_ready[k]) begin
                    perf_grant_cnt[k*32 +: 32] <= perf_grant_cnt[k*32 +: 32] + 32'd1;
                end
            end
            if (ar_valid_q && !m_ar_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

    assign m_ar_valid    = ar_valid_q;
    assign m_ar_addr     = addr_q;
    assign m_ar_len      = len_q;
    assign m_ar_id       = id_q;
    assign err_underflow = err_q;

endmodule
